// File: rtl/sparse_iaram_packer_if.sv
// ============================================================================
// Module : sparse_iaram_packer_if
// Brief  : Dense activation input stream and compressed packet output bus
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface sparse_iaram_packer_if #(
  parameter int NUM_DATA = 4,
  parameter int DATA_W   = 16,
  parameter int IDX_BITS = 4,
  parameter int CH_W     = 6,
  parameter int CNT_W    = 12
);
  logic                         in_valid;
  logic                         in_ready;
  logic [DATA_W-1:0]            in_data;
  logic [CH_W-1:0]              in_channel;
  logic                         in_last;
  logic                         pkt_valid;
  logic                         pkt_ready;
  logic [NUM_DATA*DATA_W-1:0]   pkt_data;
  logic [NUM_DATA*IDX_BITS-1:0] pkt_indices;
  logic [NUM_DATA-1:0]          pkt_slot_valid;
  logic [CH_W-1:0]              pkt_channel;
  logic                         pkt_last;
  logic [CNT_W-1:0]             chan_nnz;

  modport slave (
    input  in_valid, in_data, in_channel, in_last, pkt_ready,
    output in_ready, pkt_valid, pkt_data, pkt_indices, pkt_slot_valid,
           pkt_channel, pkt_last, chan_nnz
  );

  modport master (
    output in_valid, in_data, in_channel, in_last, pkt_ready,
    input  in_ready, pkt_valid, pkt_data, pkt_indices, pkt_slot_valid,
           pkt_channel, pkt_last, chan_nnz
  );
endinterface

`default_nettype wire

// File: rtl/sparse_iaram_packer.sv
// ============================================================================
// Module : sparse_iaram_packer
// Brief  : Packs a dense activation stream into zero-run compressed packets
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sparse_iaram_packer #(
  parameter int NUM_DATA = 4,
  parameter int DATA_W   = 16,
  parameter int IDX_BITS = 4,
  parameter int CH_W     = 6,
  parameter int CNT_W    = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  sparse_iaram_packer_if.slave   bus
);
  localparam int MAX_RUN = (1 << IDX_BITS) - 1;
  localparam int SLOT_W  = $clog2(NUM_DATA + 1);

  // S_LAST: the channel's final element filled a packet, an empty closing packet is still owed
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_LAST = 2'd2} state_t;

  state_t                       r_state, w_state_nxt;
  logic [SLOT_W-1:0]            r_cnt, w_cnt_nxt, w_cnt_new;
  logic [IDX_BITS-1:0]          r_run, w_run_nxt;
  logic [NUM_DATA*DATA_W-1:0]   r_acc_data, w_acc_data;
  logic [NUM_DATA*IDX_BITS-1:0] r_acc_idx, w_acc_idx;
  logic [CH_W-1:0]              r_chan, w_chan;
  logic [CNT_W-1:0]             r_nnz, w_nnz;
  logic [NUM_DATA-1:0]          w_mask;
  logic                         w_in_ready, w_accept, w_write, w_full, w_close, w_flush;

  logic                         r_pkt_valid;
  logic [NUM_DATA*DATA_W-1:0]   r_pkt_data;
  logic [NUM_DATA*IDX_BITS-1:0] r_pkt_idx;
  logic [NUM_DATA-1:0]          r_pkt_mask;
  logic [CH_W-1:0]              r_pkt_chan;
  logic                         r_pkt_last;
  logic [CNT_W-1:0]             r_pkt_nnz;

  assign w_in_ready = (r_state != S_LAST) && (!r_pkt_valid || bus.pkt_ready);
  assign w_flush    = (r_state == S_LAST) && (!r_pkt_valid || bus.pkt_ready);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = bus.in_valid && w_in_ready;
    w_write     = (bus.in_data != '0) || (r_run == IDX_BITS'(MAX_RUN));
    w_cnt_new   = r_cnt + SLOT_W'(w_write);
    w_full      = (w_cnt_new == SLOT_W'(NUM_DATA));
    w_close     = w_accept && (w_full || bus.in_last);
    w_chan      = (r_state == S_IDLE) ? bus.in_channel : r_chan;
    w_nnz       = ((r_state == S_IDLE) ? '0 : r_nnz) + CNT_W'(w_write);
    w_acc_data  = r_acc_data;
    w_acc_idx   = r_acc_idx;
    w_cnt_nxt   = r_cnt;
    w_run_nxt   = r_run;
    for (int i = 0; i < NUM_DATA; i++) begin
      w_mask[i] = (SLOT_W'(i) < w_cnt_new);
      if (w_write && (r_cnt == SLOT_W'(i))) begin
        w_acc_data[i*DATA_W +: DATA_W]   = bus.in_data;
        w_acc_idx[i*IDX_BITS +: IDX_BITS] = r_run;
      end
    end
    if (w_accept) begin
      w_cnt_nxt = w_close ? '0 : w_cnt_new;
      w_run_nxt = (w_write || bus.in_last) ? '0 : r_run + 1'b1;
    end
    case (r_state)
      S_LAST: begin
        if (w_flush) w_state_nxt = S_IDLE;
      end
      default: begin
        if (w_accept) begin
          if (!bus.in_last) w_state_nxt = S_FILL;
          else if (w_full)  w_state_nxt = S_LAST;
          else              w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_run       <= '0;
      r_acc_data  <= '0;
      r_acc_idx   <= '0;
      r_chan      <= '0;
      r_nnz       <= '0;
      r_pkt_valid <= 1'b0;
      r_pkt_data  <= '0;
      r_pkt_idx   <= '0;
      r_pkt_mask  <= '0;
      r_pkt_chan  <= '0;
      r_pkt_last  <= 1'b0;
      r_pkt_nnz   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_run   <= w_run_nxt;
      if (w_accept) begin
        r_chan <= w_chan;
        r_nnz  <= w_nnz;
      end
      if (w_close) begin
        r_acc_data <= '0;
        r_acc_idx  <= '0;
      end else if (w_accept) begin
        r_acc_data <= w_acc_data;
        r_acc_idx  <= w_acc_idx;
      end
      if (w_close) begin
        r_pkt_valid <= 1'b1;
        r_pkt_data  <= w_acc_data;
        r_pkt_idx   <= w_acc_idx;
        r_pkt_mask  <= w_mask;
        r_pkt_chan  <= w_chan;
        r_pkt_last  <= bus.in_last && !w_full;
        r_pkt_nnz   <= w_nnz;
      end else if (w_flush) begin
        r_pkt_valid <= 1'b1;
        r_pkt_data  <= '0;
        r_pkt_idx   <= '0;
        r_pkt_mask  <= '0;
        r_pkt_chan  <= r_chan;
        r_pkt_last  <= 1'b1;
        r_pkt_nnz   <= r_nnz;
      end else if (bus.pkt_ready) begin
        r_pkt_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.pkt_valid      = r_pkt_valid;
  assign bus.pkt_data       = r_pkt_data;
  assign bus.pkt_indices    = r_pkt_idx;
  assign bus.pkt_slot_valid = r_pkt_mask;
  assign bus.pkt_channel    = r_pkt_chan;
  assign bus.pkt_last       = r_pkt_last;
  assign bus.chan_nnz       = r_pkt_nnz;
endmodule

`default_nettype wire

// File: tb/tb_sparse_iaram_packer.sv
// ============================================================================
// Module : tb_sparse_iaram_packer
// Brief  : Directed plus randomized self-checking bench with packet-list model
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sparse_iaram_packer;
  localparam int NUM_DATA = 4;
  localparam int DATA_W   = 16;
  localparam int IDX_BITS = 4;
  localparam int CH_W     = 6;
  localparam int CNT_W    = 12;

  typedef struct {
    logic [63:0] data;
    logic [15:0] idx;
    logic [3:0]  mask;
    logic [5:0]  ch;
    logic        last;
    logic [11:0] nnz;
  } pkt_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  pkt_t exp_q[$];
  int   hs_q[$];
  int   cyc = 0;
  int   stall_left = 0;
  bit   stall_arm  = 1'b0;
  bit   rand_ready = 1'b0;
  int   waits_seen = 0;
  pkt_t mon_e;
  logic hold_prev = 1'b0;
  logic [63:0] snap_data;
  logic [38:0] snap_meta;

  sparse_iaram_packer_if #(.NUM_DATA(NUM_DATA), .DATA_W(DATA_W), .IDX_BITS(IDX_BITS),
                           .CH_W(CH_W), .CNT_W(CNT_W)) bus ();

  sparse_iaram_packer #(.NUM_DATA(NUM_DATA), .DATA_W(DATA_W), .IDX_BITS(IDX_BITS),
                        .CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Downstream readiness: optional one-shot hold after the next packet, else random or always ready
  always @(posedge clk) begin
    #2;
    if (stall_arm && bus.pkt_valid) begin
      stall_left = 3;
      stall_arm  = 1'b0;
    end
    if (stall_left > 0) begin
      bus.pkt_ready = 1'b0;
      stall_left--;
    end else begin
      bus.pkt_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Packet monitor: compares each accepted packet with the model queue and checks hold stability
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 64'(bus.pkt_valid), 64'd1);
        chk("hold_data", bus.pkt_data, snap_data);
        chk("hold_meta", 64'({bus.pkt_indices, bus.pkt_slot_valid, bus.pkt_channel,
                              bus.pkt_last, bus.chan_nnz}), 64'(snap_meta));
      end
      if (bus.pkt_valid && !bus.pkt_ready)
        chk("backpressure_in_ready", 64'(bus.in_ready), 64'd0);
      if (bus.pkt_valid && bus.pkt_ready) begin
        hs_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $error("FAIL unexpected_pkt: observed data %0h expected no packet", bus.pkt_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pkt_data", bus.pkt_data, mon_e.data);
          chk("pkt_indices", 64'(bus.pkt_indices), 64'(mon_e.idx));
          chk("pkt_slot_valid", 64'(bus.pkt_slot_valid), 64'(mon_e.mask));
          chk("pkt_channel", 64'(bus.pkt_channel), 64'(mon_e.ch));
          chk("pkt_last", 64'(bus.pkt_last), 64'(mon_e.last));
          if (mon_e.last) chk("chan_nnz", 64'(bus.chan_nnz), 64'(mon_e.nnz));
        end
      end
      hold_prev = bus.pkt_valid && !bus.pkt_ready;
      snap_data = bus.pkt_data;
      snap_meta = {bus.pkt_indices, bus.pkt_slot_valid, bus.pkt_channel, bus.pkt_last, bus.chan_nnz};
    end
  end

  // Reference: walk the channel's element list, cut packets at 4 slots and at the final element
  task automatic model_channel(input int ch, input int el[$]);
    pkt_t p;
    int   run, nnz, cnt;
    bit   last;
    run = 0; nnz = 0; cnt = 0;
    p = '{default: '0};
    for (int k = 0; k < el.size(); k++) begin
      last = (k == el.size() - 1);
      if (el[k] != 0 || run == 15) begin
        p.data[cnt*16 +: 16] = 16'(el[k]);
        p.idx[cnt*4 +: 4]    = 4'(run);
        p.mask[cnt]          = 1'b1;
        cnt++; nnz++; run = 0;
      end else begin
        run++;
      end
      if (cnt == 4) begin
        p.ch = 6'(ch); p.last = 1'b0; p.nnz = 12'(nnz);
        exp_q.push_back(p);
        p = '{default: '0};
        cnt = 0;
      end
      if (last) begin
        p.ch = 6'(ch); p.last = 1'b1; p.nnz = 12'(nnz);
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic send_elem(input int d, input int ch, input bit last);
    int waits;
    waits = 0;
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_data    = 16'(d);
    bus.in_channel = 6'(ch);
    bus.in_last    = last;
    #1;
    while (bus.in_ready !== 1'b1) begin
      waits++;
      waits_seen++;
      if (waits > 100) begin
        n_tests++;
        n_fail++;
        $error("FAIL in_ready_timeout: observed in_ready %b expected 1", bus.in_ready);
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic send_channel(input int ch, input int el[$]);
    model_channel(ch, el);
    for (int k = 0; k < el.size(); k++) send_elem(el[k], ch, k == el.size() - 1);
    idle_in();
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed simulation timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int el[$];
    int w0, len, zp, v;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_channel = '0;
    bus.in_last    = 1'b0;
    bus.pkt_ready  = 1'b1;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pkt_valid", 64'(bus.pkt_valid), 64'd0);
    chk("rst_pkt_data", bus.pkt_data, 64'd0);
    chk("rst_pkt_indices", 64'(bus.pkt_indices), 64'd0);
    chk("rst_slot_valid", 64'(bus.pkt_slot_valid), 64'd0);
    chk("rst_channel", 64'(bus.pkt_channel), 64'd0);
    chk("rst_last", 64'(bus.pkt_last), 64'd0);
    chk("rst_chan_nnz", 64'(bus.chan_nnz), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    #2 rst = 1'b1;

    el = {5, 0, 0, 7, 0, 9, -2};
    send_channel(3, el);

    el = {};
    repeat (20) el.push_back(0);
    el.push_back(4);
    send_channel(1, el);

    stall_arm = 1'b1;
    w0 = waits_seen;
    el = {1, 2, 3, 4, 5, 6, 7, 8};
    send_channel(2, el);
    chk("ch2_input_stalled", 64'(waits_seen > w0), 64'd1);
    stall_arm = 1'b0;

    el = {3, 0, 0, 0};
    send_channel(4, el);

    send_elem(11, 6, 1'b0);
    send_elem(12, 6, 1'b0);
    idle_in();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("midrst_pkt_valid", 64'(bus.pkt_valid), 64'd0);
    chk("midrst_slot_valid", 64'(bus.pkt_slot_valid), 64'd0);
    chk("midrst_chan_nnz", 64'(bus.chan_nnz), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    #2 rst = 1'b1;
    el = {8};
    send_channel(5, el);

    hs_q.delete();
    w0 = waits_seen;
    el = {};
    repeat (16) el.push_back(int'($urandom_range(1, 1000)));
    send_channel(7, el);
    chk("cont_no_stall", 64'(waits_seen - w0), 64'd0);
    chk("cont_pkt_count", 64'(hs_q.size()), 64'd5);
    for (int i = 1; i < 4 && i < hs_q.size(); i++)
      chk("cont_spacing", 64'(hs_q[i] - hs_q[i-1]), 64'd4);

    rand_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      len = int'($urandom_range(1, 40));
      zp  = (c % 3 == 0) ? 95 : 50;
      el  = {};
      for (int k = 0; k < len; k++) begin
        v = ($urandom_range(0, 99) < zp) ? 0 : int'($urandom_range(1, 65535));
        el.push_back(v);
      end
      send_channel(int'($urandom_range(0, 63)), el);
    end
    rand_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
